// File: rtl/segment_address_unit_pkg.sv
// Shared constants for the segment address path: segment indices, address geometry, bus lane codes.
// Lane helpers are shared so prefetch and data paths steer bytes identically.
package segment_address_unit_pkg;

  localparam logic [1:0] SEG_ES = 2'd0;
  localparam logic [1:0] SEG_CS = 2'd1;
  localparam logic [1:0] SEG_SS = 2'd2;
  localparam logic [1:0] SEG_DS = 2'd3;

  localparam int SAU_ADDR_WIDTH = 20;
  localparam int SAU_SEG_SHIFT  = 4;

  localparam logic [1:0] BYTESEL_LO   = 2'b01;
  localparam logic [1:0] BYTESEL_HI   = 2'b10;
  localparam logic [1:0] BYTESEL_WORD = 2'b11;

  function automatic logic [1:0] byte_lanes(input logic is_word, input logic odd);
    if (is_word) begin
      return BYTESEL_WORD;
    end else if (odd) begin
      return BYTESEL_HI;
    end else begin
      return BYTESEL_LO;
    end
  endfunction

  function automatic logic [15:0] lane_read(input logic [15:0] bus_data, input logic is_word,
                                            input logic odd);
    if (is_word) begin
      return bus_data;
    end else if (odd) begin
      return {8'h00, bus_data[15:8]};
    end else begin
      return {8'h00, bus_data[7:0]};
    end
  endfunction

endpackage

// File: rtl/segment_address_unit_phys_addr_calc.sv
// Combinational real-mode address former: (segment << SEG_SHIFT) + offset, truncated to ADDR_WIDTH.
// Shared with the prefetch unit; the carry out of the top bit is deliberately dropped (1 MB wrap).
module phys_addr_calc
  import segment_address_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = SAU_ADDR_WIDTH,
  parameter int SEG_SHIFT  = SAU_SEG_SHIFT
) (
  input  logic [15:0]           segment,
  input  logic [15:0]           offset,
  output logic [ADDR_WIDTH-1:0] phys_addr
);

  assign phys_addr = ADDR_WIDTH'({segment, {SEG_SHIFT{1'b0}}}) + ADDR_WIDTH'(offset);

endmodule

// File: rtl/segment_address_unit.sv
// Segment address unit: segment lookup, physical address formation and bus access handshake.
// Optional build macro MISALIGN_SPLIT_EN splits odd-address word accesses into two byte cycles.
module segment_address_unit
  import segment_address_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = SAU_ADDR_WIDTH,
  parameter int SEG_SHIFT  = SAU_SEG_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            seg_sel,
  input  logic                  override_en,
  input  logic [1:0]            override_sel,
  input  logic [15:0]           offset,
  input  logic                  is_word,
  input  logic                  wr_en,
  input  logic [15:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           rd_data,
  output logic [1:0]            seg_rd_sel,
  input  logic [15:0]           seg_rd_val,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_access,
  input  logic                  m_ack,
  output logic                  m_wr_en,
  output logic [1:0]            m_bytesel,
  output logic [15:0]           m_data_out,
  input  logic [15:0]           m_data_in
);

`ifdef MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEG_WAIT = 2'd1;
  localparam logic [1:0] ST_BUS      = 2'd2;
  localparam logic [1:0] ST_BUS2     = 2'd3;

  logic [1:0]            state_r;
  logic [1:0]            sel_r;
  logic [15:0]           offset_r;
  logic                  is_word_r;
  logic                  wr_en_r;
  logic [15:0]           wr_data_r;
  logic [15:0]           seg_r;
  logic                  split_r;
  logic [7:0]            byte1_r;
  logic [15:0]           calc_seg_s;
  logic [15:0]           calc_off_s;
  logic [ADDR_WIDTH-1:0] calc_addr_s;
  logic                  split_now_s;
  logic [1:0]            lanes_s;
  logic [15:0]           dout_s;

  // Segment select is live while idle so the file read overlaps the start cycle.
  always_comb begin
    if (state_r == ST_IDLE) begin
      seg_rd_sel = override_en ? override_sel : seg_sel;
    end else begin
      seg_rd_sel = sel_r;
    end
  end

  // Address source: fresh segment read on first issue, latched segment and offset+1 for the second half.
  always_comb begin
    if (state_r == ST_SEG_WAIT) begin
      calc_seg_s = seg_rd_val;
      calc_off_s = offset_r;
    end else begin
      calc_seg_s = seg_r;
      calc_off_s = offset_r + 16'd1;
    end
  end

  phys_addr_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEG_SHIFT  (SEG_SHIFT)
  ) u_phys_addr_calc (
    .segment   (calc_seg_s),
    .offset    (calc_off_s),
    .phys_addr (calc_addr_s)
  );

  // First-cycle lane steering; a split word starts with its low byte on the high lane.
  always_comb begin
    split_now_s = SPLIT_EN & is_word_r & calc_addr_s[0];
    if (split_now_s) begin
      lanes_s = BYTESEL_HI;
      dout_s  = {wr_data_r[7:0], wr_data_r[7:0]};
    end else if (is_word_r) begin
      lanes_s = byte_lanes(1'b1, calc_addr_s[0]);
      dout_s  = wr_data_r;
    end else begin
      lanes_s = byte_lanes(1'b0, calc_addr_s[0]);
      dout_s  = {wr_data_r[7:0], wr_data_r[7:0]};
    end
  end

  // Request FSM and all registered bus/host outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      sel_r      <= 2'd0;
      offset_r   <= 16'd0;
      is_word_r  <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_data_r  <= 16'd0;
      seg_r      <= 16'd0;
      split_r    <= 1'b0;
      byte1_r    <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_data    <= 16'd0;
      m_addr     <= '0;
      m_access   <= 1'b0;
      m_wr_en    <= 1'b0;
      m_bytesel  <= 2'd0;
      m_data_out <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sel_r     <= seg_rd_sel;
            offset_r  <= offset;
            is_word_r <= is_word;
            wr_en_r   <= wr_en;
            wr_data_r <= wr_data;
            busy      <= 1'b1;
            state_r   <= ST_SEG_WAIT;
          end
        end
        ST_SEG_WAIT: begin
          seg_r      <= seg_rd_val;
          split_r    <= split_now_s;
          m_addr     <= calc_addr_s;
          m_bytesel  <= lanes_s;
          m_data_out <= dout_s;
          m_wr_en    <= wr_en_r;
          m_access   <= 1'b1;
          state_r    <= ST_BUS;
        end
        ST_BUS: begin
          if (m_ack) begin
            m_access <= 1'b0;
            if (split_r) begin
              byte1_r    <= m_data_in[15:8];
              offset_r   <= calc_off_s;
              m_addr     <= calc_addr_s;
              m_bytesel  <= BYTESEL_LO;
              m_data_out <= {wr_data_r[15:8], wr_data_r[15:8]};
              state_r    <= ST_BUS2;
            end else begin
              if (!wr_en_r) begin
                rd_data <= lane_read(m_data_in, is_word_r, m_addr[0]);
              end
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end
        ST_BUS2: begin
          // One idle bus cycle separates the two halves; ack is only honoured once re-requested.
          if (!m_access) begin
            m_access <= 1'b1;
          end else if (m_ack) begin
            if (!wr_en_r) begin
              rd_data <= {m_data_in[7:0], byte1_r};
            end
            m_access <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          busy     <= 1'b0;
          m_access <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_segment_address_unit.sv
// Self-checking bench for segment_address_unit: directed spec cases plus randomized requests
// against a plain-arithmetic reference model. Honors MISALIGN_SPLIT_EN when defined.
module tb_segment_address_unit;

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  seg_sel;
  logic        override_en;
  logic [1:0]  override_sel;
  logic [15:0] offset;
  logic        is_word;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic [15:0] rd_data;
  logic [1:0]  seg_rd_sel;
  logic [15:0] seg_rd_val;
  logic [19:0] m_addr;
  logic        m_access;
  logic        m_ack;
  logic        m_wr_en;
  logic [1:0]  m_bytesel;
  logic [15:0] m_data_out;
  logic [15:0] m_data_in;

  logic [15:0] seg_file [4];
  int checks = 0;
  int errors = 0;
  string cur_tag = "init";

  segment_address_unit dut (
    .clk(clk), .reset(reset), .start(start), .seg_sel(seg_sel), .override_en(override_en),
    .override_sel(override_sel), .offset(offset), .is_word(is_word), .wr_en(wr_en),
    .wr_data(wr_data), .busy(busy), .done(done), .rd_data(rd_data), .seg_rd_sel(seg_rd_sel),
    .seg_rd_val(seg_rd_val), .m_addr(m_addr), .m_access(m_access), .m_ack(m_ack),
    .m_wr_en(m_wr_en), .m_bytesel(m_bytesel), .m_data_out(m_data_out), .m_data_in(m_data_in)
  );

  always #5 clk = ~clk;

  // Segment register file model: registered read port, one cycle latency.
  always @(posedge clk) seg_rd_val <= seg_file[seg_rd_sel];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", cur_tag, name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] phys(input logic [15:0] s, input logic [15:0] o);
    logic [31:0] v;
    v = {16'h0000, s} * 32'd16 + {16'h0000, o};
    v = v % 32'h0010_0000;
    return v[19:0];
  endfunction

  task automatic run_req(input logic [1:0] sel, input logic oen, input logic [1:0] osel,
                         input logic [15:0] off, input logic word, input logic wr,
                         input logic [15:0] wd, input logic [15:0] d1, input logic [15:0] d2,
                         input int lat, input bit hold_start);
    logic [1:0]  eff;
    logic [15:0] segv;
    logic [15:0] off2;
    logic [19:0] a1;
    logic [19:0] a2;
    logic [1:0]  exp_sel;
    logic [15:0] exp_dout;
    logic [15:0] exp_rd;
    bit          split;
    eff  = oen ? osel : sel;
    segv = seg_file[eff];
    a1   = phys(segv, off);
    off2 = off + 16'd1;
    a2   = phys(segv, off2);
    split = SPLIT && word && a1[0];
    if (split) begin
      exp_sel = 2'b10;  exp_dout = {wd[7:0], wd[7:0]};  exp_rd = {d2[7:0], d1[15:8]};
    end else if (word) begin
      exp_sel = 2'b11;  exp_dout = wd;                  exp_rd = d1;
    end else begin
      exp_sel  = a1[0] ? 2'b10 : 2'b01;
      exp_dout = {wd[7:0], wd[7:0]};
      exp_rd   = a1[0] ? {8'h00, d1[15:8]} : {8'h00, d1[7:0]};
    end
    seg_sel = sel; override_en = oen; override_sel = osel; offset = off;
    is_word = word; wr_en = wr; wr_data = wd; start = 1'b1;
    #1;
    check("seg_rd_sel", {30'd0, seg_rd_sel}, {30'd0, eff});
    step();
    if (hold_start) begin
      offset = off ^ 16'h0F0F; wr_data = ~wd; override_en = ~oen; is_word = ~word;
    end else begin
      start = 1'b0;
    end
    check("busy_accept", {31'd0, busy}, 32'd1);
    check("access_early", {31'd0, m_access}, 32'd0);
    step();
    check("access_on", {31'd0, m_access}, 32'd1);
    check("addr", {12'd0, m_addr}, {12'd0, a1});
    check("bytesel", {30'd0, m_bytesel}, {30'd0, exp_sel});
    check("wr_en", {31'd0, m_wr_en}, {31'd0, wr});
    check("data_out", {16'd0, m_data_out}, {16'd0, exp_dout});
    for (int i = 0; i < lat; i++) begin
      step();
      check("addr_hold", {11'd0, m_access, m_addr}, {11'd0, 1'b1, a1});
    end
    m_ack = 1'b1; m_data_in = d1;
    step();
    m_ack = 1'b0; m_data_in = 16'hDEAD;
    if (split) begin
      check("split_gap", {30'd0, m_access, done}, 32'd0);
      step();
      check("addr2", {11'd0, m_access, m_addr}, {11'd0, 1'b1, a2});
      check("bytesel2", {30'd0, m_bytesel}, 32'd1);
      check("data_out2", {16'd0, m_data_out}, {16'd0, wd[15:8], wd[15:8]});
      m_ack = 1'b1; m_data_in = d2;
      step();
      m_ack = 1'b0; m_data_in = 16'hDEAD;
    end
    check("done", {29'd0, done, busy, m_access}, {29'd0, 3'b100});
    if (!wr) check("rd_data", {16'd0, rd_data}, {16'd0, exp_rd});
    start = 1'b0;
    step();
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seg_sel = 2'd0; override_en = 1'b0; override_sel = 2'd0;
    offset = 16'd0; is_word = 1'b0; wr_en = 1'b0; wr_data = 16'd0; m_ack = 1'b0;
    m_data_in = 16'd0;
    seg_file[0] = 16'h2000; seg_file[1] = 16'h0F00; seg_file[2] = 16'h3000; seg_file[3] = 16'h1234;
    step(); step();
    cur_tag = "reset";
    check("ctrl", {28'd0, busy, done, m_access, m_wr_en}, 32'd0);
    check("addr", {12'd0, m_addr}, 32'd0);
    check("lanes_data", {14'd0, m_bytesel, m_data_out}, 32'd0);
    check("rd_data", {16'd0, rd_data}, 32'd0);
    #2 reset = 1'b0;
    step();

    cur_tag = "t1_byte_read_ds";
    run_req(2'd3, 1'b0, 2'd0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'hAB55, 16'h0000, 1, 1'b0);
    cur_tag = "t2_override_es_word_write";
    run_req(2'd3, 1'b1, 2'd0, 16'h0004, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 16'h0000, 0, 1'b0);
    cur_tag = "t3_wrap";
    seg_file[2] = 16'hFFFF;
    run_req(2'd2, 1'b0, 2'd0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h77AA, 16'h0000, 2, 1'b0);
    cur_tag = "t3_odd_byte_write";
    run_req(2'd1, 1'b0, 2'd0, 16'h0003, 1'b0, 1'b1, 16'h12C3, 16'h0000, 16'h0000, 0, 1'b0);
    cur_tag = "t4_odd_word_wrap";
    seg_file[0] = 16'h0000;
    run_req(2'd1, 1'b1, 2'd0, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'h12AA, 16'hCC34, 1, 1'b0);
    cur_tag = "t5_start_held";
    seg_file[3] = 16'h4321;
    run_req(2'd3, 1'b0, 2'd2, 16'h0102, 1'b1, 1'b0, 16'h5A5A, 16'h9876, 16'h0000, 3, 1'b1);
    cur_tag = "back_to_back";
    run_req(2'd3, 1'b0, 2'd0, 16'h0101, 1'b0, 1'b0, 16'h0000, 16'hC3E1, 16'h0000, 0, 1'b0);

    cur_tag = "t5_reset_abort";
    seg_sel = 2'd3; offset = 16'h0040; is_word = 1'b1; wr_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("access_before", {31'd0, m_access}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async", {30'd0, m_access, busy}, 32'd0);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_done", {29'd0, done, busy, m_access}, 32'd0);
    end

    for (int n = 0; n < 40; n++) begin
      cur_tag = $sformatf("rand%0d", n);
      for (int k = 0; k < 4; k++) seg_file[k] = 16'($urandom);
      run_req(2'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 1'($urandom),
              1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
